// File: rtl/vm_pkg.sv
// Shared vending-machine constants and types used by the key debouncer and the LED/buzzer pulse controller.
package vm_pkg;

    localparam int SYS_CLK_HZ       = 50_000_000;
    localparam int TICK_20MS_DIV    = 1_000_000;
    localparam int HOLD_TICKS_DEF   = 25;
    localparam int BLINK_TICKS_DEF  = 5;
    localparam int VM_NCH           = 4;

    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } chan_state_t;

endpackage

// File: rtl/led_pulse_ctrl_if.sv
// Event-flag in / LED-level out bundle between the vend control FSM and the pulse controller.
interface led_pulse_ctrl_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] flag_in;
    logic [NCH-1:0] blink_en;
    logic [NCH-1:0] led_out;
    logic [NCH-1:0] busy;

    modport master (
        output flag_in,
        output blink_en,
        input  led_out,
        input  busy
    );

    modport slave (
        input  flag_in,
        input  blink_en,
        output led_out,
        output busy
    );
endinterface

// File: rtl/led_chan.sv
// One LED/buzzer channel: a trigger starts a timed on-window, either steady or blinking.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   CH_IDLE   | output off, counters parked at 0
//   CH_ACTIVE | window running; remaining counts ticks, phase paces blink
module led_chan
    import vm_pkg::*;
#(
    parameter int HOLD_TICKS  = HOLD_TICKS_DEF,
    parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
    input  logic sclk,
    input  logic rst,
    input  logic tick,
    input  logic flag,
    input  logic blink,
    output logic led,
    output logic busy
);

    localparam int RW = $clog2(HOLD_TICKS + 1);
    localparam int PW = $clog2(BLINK_TICKS + 1);
    localparam logic [RW-1:0] REM_LOAD   = RW'(HOLD_TICKS);
    localparam logic [PW-1:0] PHASE_LOAD = PW'(BLINK_TICKS);

    chan_state_t   state, state_nxt;
    logic [RW-1:0] remaining, remaining_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic          mode, mode_nxt;
    logic          led_nxt;

    always_ff @(posedge sclk) begin
        if (rst) begin
            state     <= CH_IDLE;
            remaining <= '0;
            phase     <= '0;
            mode      <= 1'b0;
            led       <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            phase     <= phase_nxt;
            mode      <= mode_nxt;
            led       <= led_nxt;
        end
    end

    // A flag always wins over a same-cycle tick, so a retrigger never loses time.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        phase_nxt     = phase;
        mode_nxt      = mode;
        led_nxt       = led;
        if (flag) begin
            state_nxt     = CH_ACTIVE;
            remaining_nxt = REM_LOAD;
            phase_nxt     = PHASE_LOAD;
            mode_nxt      = blink;
            led_nxt       = 1'b1;
        end else if (state == CH_ACTIVE && tick) begin
            if (remaining == RW'(1)) begin
                state_nxt     = CH_IDLE;
                remaining_nxt = '0;
                phase_nxt     = '0;
                led_nxt       = 1'b0;
            end else begin
                remaining_nxt = remaining - RW'(1);
                if (mode) begin
                    if (phase == PW'(1)) begin
                        led_nxt   = ~led;
                        phase_nxt = PHASE_LOAD;
                    end else begin
                        phase_nxt = phase - PW'(1);
                    end
                end
            end
        end
    end

    assign busy = (state == CH_ACTIVE);

endmodule

// File: rtl/led_pulse_ctrl.sv
// Shared 20 ms tick prescaler feeding NCH independent LED/buzzer pulse channels.
module led_pulse_ctrl
    import vm_pkg::*;
#(
    parameter int CLK_DIV     = TICK_20MS_DIV,
    parameter int HOLD_TICKS  = HOLD_TICKS_DEF,
    parameter int BLINK_TICKS = BLINK_TICKS_DEF,
    parameter int NCH         = VM_NCH
) (
    input  logic            sclk,
    input  logic            rst,
    led_pulse_ctrl_if.slave bus
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic [DW-1:0] presc;
    logic          tick;

    // Free-running: triggers never restart it, so on-time varies by up to one tick.
    always_ff @(posedge sclk) begin
        if (rst) begin
            presc <= '0;
        end else if (presc == DIV_MAX) begin
            presc <= '0;
        end else begin
            presc <= presc + DW'(1);
        end
    end

    assign tick = (presc == DIV_MAX);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        led_chan #(
            .HOLD_TICKS  (HOLD_TICKS),
            .BLINK_TICKS (BLINK_TICKS)
        ) u_chan (
            .sclk  (sclk),
            .rst   (rst),
            .tick  (tick),
            .flag  (bus.flag_in[i]),
            .blink (bus.blink_en[i]),
            .led   (bus.led_out[i]),
            .busy  (bus.busy[i])
        );
    end

endmodule

// File: tb/tb_led_pulse_ctrl.sv
// Directed bench for led_pulse_ctrl with CLK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=1.
module tb_led_pulse_ctrl;

    logic sclk;
    logic rst;
    int   n_checks;
    int   n_pass;

    led_pulse_ctrl_if #(.NCH(4)) bus ();

    led_pulse_ctrl #(
        .CLK_DIV     (4),
        .HOLD_TICKS  (3),
        .BLINK_TICKS (1),
        .NCH         (4)
    ) u_dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance n edges; after each, compare led_out and busy against the expected levels.
    task automatic cyc(input string tag, input logic [3:0] exp_led, input logic [3:0] exp_busy,
                       input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sclk);
            #1;
            chk({tag, "_led"}, bus.led_out, exp_led);
            chk({tag, "_busy"}, bus.busy, exp_busy);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.flag_in  = 4'b1111;
        bus.blink_en = 4'b0000;

        // Reset beats a held flag on every channel.
        cyc("reset", 4'b0000, 4'b0000, 3);
        rst         = 1'b0;
        bus.flag_in = 4'b0000;
        cyc("idle", 4'b0000, 4'b0000, 1);

        // Prescaler now 1: steady pulse on ch0; ticks consumed 2, 6 and 10 edges later.
        bus.flag_in = 4'b0001;
        cyc("steady_on", 4'b0001, 4'b0001, 1);
        bus.flag_in = 4'b0000;
        cyc("steady_hold", 4'b0001, 4'b0001, 9);
        cyc("steady_off", 4'b0000, 4'b0000, 1);

        // Prescaler now 0: blink on ch2 toggles at each tick.
        bus.flag_in  = 4'b0100;
        bus.blink_en = 4'b0100;
        cyc("blink_on", 4'b0100, 4'b0100, 1);
        bus.flag_in  = 4'b0000;
        bus.blink_en = 4'b0000;
        cyc("blink_ph1", 4'b0100, 4'b0100, 2);
        cyc("blink_ph2", 4'b0000, 4'b0100, 4);
        cyc("blink_ph3", 4'b0100, 4'b0100, 4);
        cyc("blink_off", 4'b0000, 4'b0000, 1);

        // Retrigger ch1 in the cycle of its second tick; the flag wins, full reload.
        bus.flag_in = 4'b0010;
        cyc("retrig_on", 4'b0010, 4'b0010, 1);
        bus.flag_in = 4'b0000;
        cyc("retrig_pre", 4'b0010, 4'b0010, 6);
        bus.flag_in = 4'b0010;
        cyc("retrig_hit", 4'b0010, 4'b0010, 1);
        bus.flag_in = 4'b0000;
        cyc("retrig_hold", 4'b0010, 4'b0010, 11);
        cyc("retrig_off", 4'b0000, 4'b0000, 1);

        // Two channels together, then reset mid-window.
        bus.flag_in = 4'b1010;
        cyc("pair_on", 4'b1010, 4'b1010, 1);
        bus.flag_in = 4'b0000;
        cyc("pair_hold", 4'b1010, 4'b1010, 3);
        rst = 1'b1;
        cyc("mid_reset", 4'b0000, 4'b0000, 1);
        rst = 1'b0;

        // Prescaler restarted at 0, so a pulse now gives a 10-cycle window.
        bus.flag_in = 4'b0001;
        cyc("post_rst_on", 4'b0001, 4'b0001, 1);
        bus.flag_in = 4'b0000;
        cyc("post_rst_hold", 4'b0001, 4'b0001, 10);
        cyc("post_rst_off", 4'b0000, 4'b0000, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
